// File: rtl/imem_uart_loader_pkg.sv
// Shared constants for the instruction memory loader and the CPU fetch path.
// Holds the instruction memory geometry, the loader FSM state encoding and the
// error codes reported on err_code.
package imem_uart_loader_pkg;

  // Instruction memory geometry, shared with the CPU fetch path
  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned IMEM_DATA_W = 16;
  localparam int unsigned IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  // Loader framing defaults
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned TIMEOUT_DEF   = 50000;

  // Loader FSM state encoding
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_COUNT   = 3'd3,
    S_DATA_HI = 3'd4,
    S_DATA_LO = 3'd5,
    S_CSUM    = 3'd6
  } loader_state_t;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // True when a burst of count words starting at start would run past the top address
  function automatic logic burst_overflows(input logic [31:0] start,
                                           input logic [31:0] count,
                                           input int unsigned aw);
    return (start + count) > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/imem_uart_loader_byte_timer.sv
// Inter-byte timer for the loader. Counts clk cycles since the last clear and
// flags expiry once TIMEOUT cycles have elapsed; the count saturates there.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       restart the count (byte accepted or loader idle)
//   expired_c   combinational: TIMEOUT cycles have passed without a clear
module loader_byte_timer #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired_c = (cnt == CNT_W'(TIMEOUT));

  // Saturating cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Writer side of the instruction memory: parses framed program images from the
// UART byte stream and drives the memory write port, holding the CPU meanwhile.
// Frame: SYNC, ADDR_HI, ADDR_LO, COUNT, COUNT x {DATA_HI, DATA_LO}, CSUM.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   wr_en/addr/data    instruction memory write port, one strobe per word
//   cpu_hold           high from SYNC acceptance until frame end
//   load_done          pulse: frame complete with good checksum
//   load_err           pulse: frame aborted; err_code holds the reason
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [IMEM_DATA_W-1:0] wr_data,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             err_code
);

  loader_state_t state_q, state_d;

  logic [7:0]             sum_q, sum_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [7:0]             rem_q, rem_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             addr_hi_q, addr_hi_d;
  logic                   wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_d;
  logic [IMEM_DATA_W-1:0] wr_data_d;
  logic                   cpu_hold_d;
  logic                   load_done_d;
  logic                   load_err_d;
  logic [1:0]             err_code_d;

  logic                   abort;
  logic [1:0]             abort_code;
  logic [15:0]            addr_full;
  logic                   timer_expired_c;

  // Timer is held clear while idle so a new frame always starts with a full budget
  loader_byte_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_byte_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     ((state_q == S_IDLE) || rx_valid),
    .expired_c (timer_expired_c)
  );

  assign addr_full = {addr_hi_q, rx_data};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    hi_d        = hi_q;
    addr_hi_d   = addr_hi_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    cpu_hold_d  = cpu_hold;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    err_code_d  = err_code;
    abort       = 1'b0;
    abort_code  = ERR_NONE;

    // Running sum covers every byte after SYNC, CSUM included
    if (rx_valid && (state_q != S_IDLE)) begin
      sum_d = sum_q + rx_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d    = S_ADDR_HI;
          cpu_hold_d = 1'b1;
          sum_d      = 8'h00;
        end
      end
      S_ADDR_HI: begin
        if (rx_valid) begin
          addr_hi_d = rx_data;
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_valid) begin
          if ((32'(addr_full) >> ADDR_W) != 32'd0) begin
            abort      = 1'b1;
            abort_code = ERR_RANGE;
          end else begin
            ptr_d   = addr_full[ADDR_W-1:0];
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        // Whole-burst range check up front so no write can wrap past the top
        if (rx_valid) begin
          if ((rx_data == 8'h00) ||
              burst_overflows(32'(ptr_q), 32'(rx_data), ADDR_W)) begin
            abort      = 1'b1;
            abort_code = ERR_RANGE;
          end else begin
            rem_d   = rx_data;
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = {hi_q, rx_data};
          ptr_d     = ptr_q + ADDR_W'(1);
          rem_d     = rem_q - 8'd1;
          state_d   = (rem_q == 8'd1) ? S_CSUM : S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (sum_d == 8'h00) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CSUM;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
      end
    endcase

    if ((state_q != S_IDLE) && !rx_valid && timer_expired_c) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end

    // Abort: already-written words are kept, only the frame is dropped
    if (abort) begin
      state_d    = S_IDLE;
      cpu_hold_d = 1'b0;
      load_err_d = 1'b1;
      err_code_d = abort_code;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      addr_hi_q <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      addr_hi_q <= addr_hi_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      cpu_hold  <= cpu_hold_d;
      load_done <= load_done_d;
      load_err  <= load_err_d;
      err_code  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with TIMEOUT shortened to 20 cycles.
module tb_imem_uart_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wa_log[$];
  logic [15:0] wd_log[$];
  int          n_done = 0;
  int          n_err  = 0;

  imem_uart_loader #(
    .ADDR_W    (10),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write and pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
    end
    if (load_done) n_done++;
    if (load_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  byte_q_t q;
  int      base_w;
  int      base_d;
  int      base_e;
  bit      seen;

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    check("reset_outputs", 32'({wr_en, cpu_hold, load_done, load_err, err_code, wr_addr, wr_data}), 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: good two-word frame at 100
    base_w = wa_log.size(); base_d = n_done;
    send_byte(8'hA5);
    check("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
    q = '{8'h00, 8'h64, 8'h02, 8'h0D, 8'h00};
    send_seq(q);
    check("t1_w0", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 10'd100, 16'h0D00}));
    q = '{8'h0D, 8'h11};
    send_seq(q);
    check("t1_w1", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 10'd101, 16'h0D11}));
    check("t1_hold_before_csum", 32'(cpu_hold), 32'd1);
    send_byte(8'h6F);
    check("t1_done_hold", 32'({load_done, cpu_hold, load_err}), 32'b100);
    idle(1);
    check("t1_done_pulse", 32'({load_done, wr_en}), 32'd0);
    check("t1_wr_hold", 32'({wr_addr, wr_data}), 32'({10'd101, 16'h0D11}));
    idle(2);
    check("t1_nwrites", 32'(wa_log.size() - base_w), 32'd2);
    check("t1_ndone", 32'(n_done - base_d), 32'd1);

    // 2: bad checksum, words stay written
    base_w = wa_log.size(); base_d = n_done;
    q = '{8'hA5, 8'h00, 8'h64, 8'h02, 8'h0D, 8'h00, 8'h0D, 8'h11, 8'h70};
    send_seq(q);
    check("t2_err", 32'({load_err, err_code, load_done, cpu_hold}), 32'b1_10_0_0);
    idle(2);
    check("t2_nwrites", 32'(wa_log.size() - base_w), 32'd2);
    check("t2_ndone", 32'(n_done - base_d), 32'd0);

    // 3: range errors at COUNT
    base_w = wa_log.size(); base_e = n_err;
    q = '{8'hA5, 8'h03, 8'hFF, 8'h02};
    send_seq(q);
    check("t3_overflow_err", 32'({load_err, err_code, cpu_hold}), 32'b1_01_0);
    q = '{8'h0D, 8'h00, 8'h0D, 8'h11};
    send_seq(q);
    idle(2);
    check("t3_nwrites", 32'(wa_log.size() - base_w), 32'd0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq(q);
    check("t3_zero_count_err", 32'({load_err, err_code}), 32'b1_01);
    idle(2);
    check("t3_nerr", 32'(n_err - base_e), 32'd2);

    // 4: timeout mid-frame, then a good frame
    base_w = wa_log.size();
    q = '{8'hA5, 8'h00, 8'hC8, 8'h01, 8'h0D};
    send_seq(q);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (load_err) begin
        seen = 1'b1;
        break;
      end
      if (i < 15) check("t4_hold_waiting", 32'(cpu_hold), 32'd1);
      @(negedge clk);
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    check("t4_timeout_code", 32'({err_code, cpu_hold}), 32'b11_0);
    check("t4_nwrites", 32'(wa_log.size() - base_w), 32'd0);
    base_d = n_done;
    q = '{8'hA5, 8'h00, 8'h64, 8'h02, 8'h0D, 8'h00, 8'h0D, 8'h11, 8'h6F};
    send_seq(q);
    idle(2);
    check("t4_after_nwrites", 32'(wa_log.size() - base_w), 32'd2);
    if (wa_log.size() - base_w == 2)
      check("t4_after_w1", 32'({wa_log[base_w + 1], wd_log[base_w + 1]}), 32'({10'd101, 16'h0D11}));
    check("t4_after_ndone", 32'(n_done - base_d), 32'd1);

    // 5: leading garbage ignored, in-frame SYNC value is data
    base_w = wa_log.size(); base_d = n_done;
    q = '{8'h12, 8'h34};
    send_seq(q);
    idle(1);
    check("t5_no_hold", 32'(cpu_hold), 32'd0);
    q = '{8'hA5, 8'h01, 8'h2C, 8'h01, 8'hA5, 8'h5A};
    send_seq(q);
    check("t5_w0", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 10'd300, 16'hA55A}));
    send_byte(8'hD3);
    check("t5_done", 32'({load_done, cpu_hold}), 32'b10);
    idle(2);
    check("t5_nwrites", 32'(wa_log.size() - base_w), 32'd1);
    check("t5_ndone", 32'(n_done - base_d), 32'd1);

    // 6: async reset between DATA_HI and DATA_LO, then back-to-back frame
    base_w = wa_log.size();
    q = '{8'hA5, 8'h00, 8'h64, 8'h02, 8'h0D};
    send_seq(q);
    check("t6_hold_pre_reset", 32'(cpu_hold), 32'd1);
    #2 reset = 1'b1;
    #1 check("t6_async_reset", 32'({wr_en, cpu_hold, load_done, load_err, err_code, wr_addr, wr_data}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("t6_nwrites_reset", 32'(wa_log.size() - base_w), 32'd0);
    base_d = n_done;
    q = '{8'hA5, 8'h00, 8'h64, 8'h02, 8'h0D, 8'h00, 8'h0D, 8'h11, 8'h6F};
    send_seq(q);
    check("t6_done", 32'(load_done), 32'd1);
    idle(2);
    check("t6_nwrites", 32'(wa_log.size() - base_w), 32'd2);
    if (wa_log.size() - base_w == 2) begin
      check("t6_w0", 32'({wa_log[base_w], wd_log[base_w]}), 32'({10'd100, 16'h0D00}));
      check("t6_w1", 32'({wa_log[base_w + 1], wd_log[base_w + 1]}), 32'({10'd101, 16'h0D11}));
    end
    check("t6_ndone", 32'(n_done - base_d), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
